// File: rtl/ypc_pkg.sv
// rtl/ypc_pkg.sv - shared encodings, FSM states and immediate helpers for the YPC core
package ypc_pkg;

  localparam logic [6:0] OP_IMM = 7'b001_0011;
  localparam logic [6:0] OP     = 7'b011_0011;
  localparam logic [6:0] LUI    = 7'b011_0111;
  localparam logic [6:0] AUIPC  = 7'b001_0111;
  localparam logic [6:0] JAL    = 7'b110_1111;
  localparam logic [6:0] JALR   = 7'b110_0111;
  localparam logic [6:0] SYSTEM = 7'b111_0011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b000_0000;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [4:0]  REG_A0 = 5'd10;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_WAIT_RSP = 2'd1,
    S_EXEC     = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ypc_regfile.sv
// rtl/ypc_regfile.sv - architectural register file, two async reads, one sync write
module ypc_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic [AW-1:0]   i_ra_addr,
  output logic [XLEN-1:0] o_ra_data,
  input  logic [AW-1:0]   i_rb_addr,
  output logic [XLEN-1:0] o_rb_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Contents are deliberately left unreset; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
  assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/ypc_multicycle_core.sv
// rtl/ypc_multicycle_core.sv - multi-cycle YPC core: handshake fetch, RV32I/E subset exec, halt
module ypc_multicycle_core
  import ypc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc,
  output logic            halt,
  output logic            illegal,
  output logic [XLEN-1:0] ret
);

  localparam int AW = $clog2(NREGS);

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [31:0]     r_inst;
  logic            r_halt, r_illegal;
  logic [XLEN-1:0] r_ret;

  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3;
  logic [4:0] w_rd, w_rs1, w_rs2, w_rb_idx;
  logic       w_rd_ok, w_rs1_ok, w_rs2_ok, w_add_ok;

  logic [XLEN-1:0] w_rs1_data, w_rb_data;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_j, w_pc4, w_jalr_sum;

  logic            w_legal, w_ebreak, w_jump;
  logic            w_use_rd, w_use_rs1, w_use_rs2;
  logic [XLEN-1:0] w_result, w_target;
  logic            w_ok, w_exec, w_stop, w_we;

  assign w_opcode = r_inst[6:0];
  assign w_rd     = r_inst[11:7];
  assign w_funct3 = r_inst[14:12];
  assign w_rs1    = r_inst[19:15];
  assign w_rs2    = r_inst[24:20];
  assign w_funct7 = r_inst[31:25];

  assign w_rd_ok  = int'(w_rd)  < NREGS;
  assign w_rs1_ok = int'(w_rs1) < NREGS;
  assign w_rs2_ok = int'(w_rs2) < NREGS;

  // Port B serves rs2 only for a fully legal add; otherwise it reads a0 for the halt capture.
  assign w_add_ok = (w_opcode == OP) && (w_funct3 == F3_ADD) && (w_funct7 == F7_ADD) &&
                    w_rd_ok && w_rs1_ok && w_rs2_ok;
  assign w_rb_idx = w_add_ok ? w_rs2 : REG_A0;

  assign w_imm_i    = XLEN'($signed(imm_i(r_inst)));
  assign w_imm_u    = XLEN'($signed(imm_u(r_inst)));
  assign w_imm_j    = XLEN'($signed(imm_j(r_inst)));
  assign w_pc4      = r_pc + XLEN'(4);
  assign w_jalr_sum = w_rs1_data + w_imm_i;

  ypc_regfile #(
    .NREGS (NREGS),
    .XLEN  (XLEN)
  ) u_regfile (
    .clk       (clk),
    .i_ra_addr (w_rs1[AW-1:0]),
    .o_ra_data (w_rs1_data),
    .i_rb_addr (w_rb_idx[AW-1:0]),
    .o_rb_data (w_rb_data),
    .i_we      (w_we),
    .i_waddr   (w_rd[AW-1:0]),
    .i_wdata   (w_result)
  );

  always_comb begin
    w_legal   = 1'b0;
    w_ebreak  = 1'b0;
    w_jump    = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_result  = '0;
    w_target  = '0;
    if (r_inst == EBREAK) begin
      w_legal  = 1'b1;
      w_ebreak = 1'b1;
    end else begin
      case (w_opcode)
        OP_IMM: if (w_funct3 == F3_ADD) begin
          w_legal   = 1'b1;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_result  = w_rs1_data + w_imm_i;
        end
        OP: if ((w_funct3 == F3_ADD) && (w_funct7 == F7_ADD)) begin
          w_legal   = 1'b1;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_result  = w_rs1_data + w_rb_data;
        end
        LUI: begin
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_result = w_imm_u;
        end
        AUIPC: begin
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_result = r_pc + w_imm_u;
        end
        JAL: begin
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_jump   = 1'b1;
          w_result = w_pc4;
          w_target = r_pc + w_imm_j;
        end
        JALR: if (w_funct3 == F3_ADD) begin
          w_legal   = 1'b1;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_jump    = 1'b1;
          w_result  = w_pc4;
          w_target  = {w_jalr_sum[XLEN-1:1], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign w_ok = w_legal &&
                (!w_use_rd  || w_rd_ok) &&
                (!w_use_rs1 || w_rs1_ok) &&
                (!w_use_rs2 || w_rs2_ok) &&
                !(w_jump && w_target[1]);

  assign w_exec = (r_state == S_EXEC);
  assign w_stop = w_exec && (w_ebreak || !w_ok);
  // Gating with reset keeps a write from landing on an edge that coincides with reset assertion.
  assign w_we   = w_exec && w_ok && !w_ebreak && w_use_rd && (w_rd != 5'd0) && reset;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_FETCH: begin
        if (imem_req_valid && imem_req_ready) w_state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (imem_rsp_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_stop) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = w_jump ? w_target : w_pc4;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
      r_ret     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if ((r_state == S_WAIT_RSP) && imem_rsp_valid) r_inst <= imem_rsp_data;
      if (w_stop) begin
        r_halt    <= 1'b1;
        r_illegal <= !w_ok;
        r_ret     <= w_rb_data;
      end
    end
  end

  assign imem_req_valid = (r_state == S_FETCH) && reset;
  assign imem_addr      = r_pc;
  assign retire         = w_exec && w_ok;
  assign retire_pc      = retire ? r_pc : '0;
  assign halt           = r_halt;
  assign illegal        = r_illegal;
  assign ret            = r_ret;

endmodule
